sd_data_tx: RTL and testbench
=============================

// Module: sd_data_tx
// PURPOSE
//  SD-clock-domain write-data transmitter: drains one BLK_BYTES block from a dual-clock FIFO read port
//  (sd side, FIFO_ADR) and drives it onto the 4-bit SD DAT bus with start bit, per-line CRC16 and end bit.
//  Sits directly downstream of the sd-side read port of the 4-channel dual-clock FIFO; stops the card clock on FIFO underrun.
// PARAMETERS
//  BLK_BYTES  512   bytes per data block (>=2)
//  FIFO_ADR   2'd0  FIFO channel index driven on fifo_adr_o
// PORTS
//  sd_clk      in   1  SD-domain clock
//  rst         in   1  reset, asynchronous, active-high
//  start_i     in   1  pulse: send one block (ignored while busy_o)
//  abort_i     in   1  sync abort; return to IDLE next edge
//  fifo_empty_i in  1  FIFO empty flag (sd side, already synchronised)
//  fifo_dat_i  in   8  FIFO read data, valid 1 cycle after fifo_re_o
//  fifo_adr_o  out  2  constant FIFO_ADR
//  fifo_re_o   out  1  FIFO read strobe, one byte per asserted cycle
//  dat_o       out  4  SD DAT[3:0]
//  dat_oe_o    out  1  DAT output enable
//  clk_stop_o  out  1  request to gate card clock (underrun stall)
//  busy_o      out  1  block in progress
//  done_o      out  1  1-cycle pulse after end bit
// BEHAVIOUR
//  Reset: dat_o=4'hF, dat_oe_o=0, fifo_re_o=0, clk_stop_o=0, busy_o=0, done_o=0, all counters/CRC 0, IDLE.
//  FSM: IDLE -> FETCH -> START -> DATA -> CRC -> STOP -> IDLE.
//   IDLE : start_i -> FETCH, busy_o=1, byte/request counters cleared.
//   FETCH: wait prefetch reg valid; then START. dat_oe_o=0.
//   START: 1 cycle dat_o=4'h0, oe=1; prefetch reg -> shift reg, CRCs cleared.
//   DATA : 2*BLK_BYTES nibble cycles, high nibble (bits 7:4) first; DAT[i]=nibble bit i.
//   CRC  : 16 cycles; DAT[i]=crc_i MSB first.
//   STOP : 1 cycle dat_o=4'hF, oe=1; then IDLE, done_o=1, oe=0, busy_o=0.
//  Prefetch: 1-byte nxt reg + valid flag + in-flight flag. fifo_re_o=1 iff busy & !fifo_empty_i
//   & !nxt_valid & !inflight & requested<BLK_BYTES. Byte captured into nxt the cycle after.
//   Sustains 1 byte / 2 cycles with no stall when FIFO never empty. Never reads more than BLK_BYTES.
//  Underrun: at a byte boundary (after low nibble) with nxt not valid and bytes remaining -> hold
//   state, dat_o, dat_oe_o and CRCs; clk_stop_o=1 until nxt valid; resume with high nibble of next byte.
//  CRC16: per line, poly x^16+x^12+x^5+1, init 0, updated only on DATA cycles that advance.
//  Counters: nibble count width $clog2(2*BLK_BYTES+1); CRC count 4 bits; no wrap inside a block.
//  start_i while busy_o: ignored. start_i same cycle as done_o: ignored (IDLE entered next edge).
//  abort_i (any state but IDLE): next edge IDLE, oe=0, dat_o=F, clk_stop_o=0, no done_o,
//   nxt/inflight cleared; in-flight byte discarded (lost from FIFO, host must flush channel).
//  abort_i and start_i together: abort wins.
//  Async rst mid-block: immediate reset values; no further FIFO reads.
// STRUCTURE
//  Shared package: FSM state encodings, CRC16 polynomial constant 16'h1021, DAT idle value 4'hF.
//  One sub-module: sd_crc16_1b (serial 1-bit CRC16 w/ enable, clear), instantiated x4.
//  Top holds FSM, prefetch reg, shift reg, counters.
// TESTING
//  BLK_BYTES=4, FIFO preloaded 00 00 00 00, start -> 1 start cycle DAT=0, 8 DATA cycles DAT=0, 16 CRC cycles DAT=0, STOP DAT=F, done_o 1 pulse.
//  BLK_BYTES=4, bytes A5 3C .. -> DATA nibbles A,5,3,C..; CRC lines match bench per-line CRC16 model; exactly 4 fifo_re_o pulses.
//  FIFO empties after byte 2 for 10 cycles -> clk_stop_o=1 for ~10 cycles, dat_o frozen, CRC identical to no-stall run.
//  abort_i mid-DATA -> next cycle oe=0, dat_o=F, busy_o=0, no done_o; new start then sends fresh block.
//  start_i held during busy + start at done cycle -> exactly one block sent; 5th byte not read.
//  rst asserted mid-CRC -> outputs at reset values same cycle, fifo_re_o stays 0.

Source files
------------

// File: rtl/sd_data_tx_pkg.sv
// ---------------------------------------------------------------------------
// sd_data_tx_pkg
//   Shared definitions for the SD write-data transmitter:
//     state_t     - transmitter FSM state encoding
//     CRC16_POLY  - CRC16 polynomial x^16+x^12+x^5+1 (implicit x^16 dropped)
//     DAT_IDLE    - value driven on DAT[3:0] while the bus is idle
//     crc16_step  - one serial CRC16 update for a single input bit
// ---------------------------------------------------------------------------
package sd_data_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_CRC   = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [3:0]  DAT_IDLE   = 4'hF;

  // MSB-first serial CRC16: feedback is the incoming bit XOR the current MSB.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    return {crc[14:0], 1'b0} ^ ((din ^ crc[15]) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sd_crc16_1b.sv
// ---------------------------------------------------------------------------
// sd_crc16_1b
//   Serial (1 bit per clock) CRC16 generator for one SD DAT line.
//   Ports:
//     clk  in   clock
//     rst  in   asynchronous active-high reset, clears the CRC
//     clr  in   synchronous clear (takes priority over en)
//     en   in   advance the CRC by one bit
//     din  in   data bit fed into the CRC when en is high
//     crc  out  current CRC remainder (16 bits)
// ---------------------------------------------------------------------------
module sd_crc16_1b
  import sd_data_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= 16'h0000;
    end else if (clr) begin
      crc <= 16'h0000;
    end else if (en) begin
      crc <= crc16_step(crc, din);
    end
  end

endmodule

// File: rtl/sd_data_tx.sv
// ---------------------------------------------------------------------------
// sd_data_tx
//   SD-clock-domain write-data transmitter. Drains one BLK_BYTES block from
//   the sd-side read port of a dual-clock FIFO and sends it on the 4-bit DAT
//   bus as: start bit (DAT=0), 2*BLK_BYTES nibbles (high nibble first),
//   16 CRC16 bits per line (MSB first), end bit (DAT=F). Requests the card
//   clock to be stopped while the FIFO cannot keep up.
//   Parameters:
//     BLK_BYTES    bytes per data block (>= 2)
//     FIFO_ADR     FIFO channel index driven on fifo_adr_o
//   Ports:
//     sd_clk       in   SD-domain clock
//     rst          in   asynchronous active-high reset
//     start_i      in   pulse: send one block (ignored while busy)
//     abort_i      in   synchronous abort, back to idle on the next edge
//     fifo_empty_i in   FIFO empty flag (sd side)
//     fifo_dat_i   in   FIFO read data, valid one cycle after fifo_re_o
//     fifo_adr_o   out  constant FIFO channel index
//     fifo_re_o    out  FIFO read strobe, one byte per asserted cycle
//     dat_o        out  SD DAT[3:0]
//     dat_oe_o     out  DAT output enable
//     clk_stop_o   out  card clock stop request (FIFO underrun)
//     busy_o       out  block in progress
//     done_o       out  one-cycle pulse after the end bit
// ---------------------------------------------------------------------------
module sd_data_tx
  import sd_data_tx_pkg::*;
#(
  parameter int          BLK_BYTES = 512,
  parameter logic [1:0]  FIFO_ADR  = 2'd0
) (
  input  logic       sd_clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_dat_i,
  output logic [1:0] fifo_adr_o,
  output logic       fifo_re_o,
  output logic [3:0] dat_o,
  output logic       dat_oe_o,
  output logic       clk_stop_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int NIB_W = $clog2(2*BLK_BYTES + 1);
  localparam int REQ_W = $clog2(BLK_BYTES + 1);
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(2*BLK_BYTES);
  localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(BLK_BYTES);

  state_t            state;
  logic [7:0]        nxt;
  logic              nxt_valid;
  logic              inflight;
  logic [7:0]        shift;
  logic [REQ_W-1:0]  req_cnt;
  logic [NIB_W-1:0]  nib_cnt;
  logic [3:0]        crc_cnt;

  logic [3:0][15:0]  crc;
  logic [3:0]        crc_msb;
  logic [3:0]        crc_bit_nxt;
  logic              crc_clr;
  logic              crc_en;
  logic [3:0]        crc_din;

  logic              launch;
  logic              avail;
  logic              at_boundary;
  logic              consume;
  logic [7:0]        byte_in;

  assign fifo_adr_o = FIFO_ADR;

  // Only one byte is ever requested ahead: nothing held, nothing on the way.
  assign fifo_re_o = busy_o & ~fifo_empty_i & ~nxt_valid & ~inflight & (req_cnt < REQ_LAST);

  // A byte arriving this cycle is treated as available and bypasses the
  // prefetch register; without this bypass the prefetch loop needs three
  // cycles per byte and could not keep up with two nibbles per byte.
  assign avail   = nxt_valid | inflight;
  assign byte_in = nxt_valid ? nxt : fifo_dat_i;

  // start_i in the done_o cycle is dropped; abort_i always wins.
  assign launch = (state == ST_IDLE) & start_i & ~abort_i & ~done_o;

  // Next DATA edge would load the high nibble of a new byte.
  assign at_boundary = (nib_cnt != NIB_LAST) && !nib_cnt[0];

  // CRC enable/data follow exactly the nibble loaded onto dat_o at the
  // same edge, so a stalled boundary never advances the CRCs.
  always_comb begin
    consume = 1'b0;
    crc_clr = 1'b0;
    crc_en  = 1'b0;
    crc_din = shift[7:4];
    if (!abort_i) begin
      case (state)
        ST_FETCH: begin
          if (avail) begin
            consume = 1'b1;
            crc_clr = 1'b1;
          end
        end
        ST_START: begin
          crc_en  = 1'b1;
          crc_din = shift[7:4];
        end
        ST_DATA: begin
          if (nib_cnt[0]) begin
            crc_en  = 1'b1;
            crc_din = shift[3:0];
          end else if (at_boundary && avail) begin
            consume = 1'b1;
            crc_en  = 1'b1;
            crc_din = byte_in[7:4];
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_crc
    sd_crc16_1b u_crc (
      .clk (sd_clk),
      .rst (rst),
      .clr (crc_clr),
      .en  (crc_en),
      .din (crc_din[i]),
      .crc (crc[i])
    );
    assign crc_msb[i]     = crc[i][15];
    // Only used while crc_cnt < 15, so the subtraction never wraps in use.
    assign crc_bit_nxt[i] = crc[i][4'd14 - crc_cnt];
  end

  // Prefetch: one held byte plus one byte in flight from the FIFO.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      nxt       <= 8'h00;
      nxt_valid <= 1'b0;
      inflight  <= 1'b0;
      req_cnt   <= '0;
    end else if (abort_i && state != ST_IDLE) begin
      // A byte already requested is dropped; the FIFO channel needs a flush.
      nxt_valid <= 1'b0;
      inflight  <= 1'b0;
    end else begin
      if (launch) begin
        req_cnt <= '0;
      end else if (fifo_re_o) begin
        req_cnt <= req_cnt + 1'b1;
      end
      inflight <= fifo_re_o;
      if (inflight && !consume) begin
        nxt       <= fifo_dat_i;
        nxt_valid <= 1'b1;
      end else if (consume) begin
        nxt_valid <= 1'b0;
      end
    end
  end

  // Transmit FSM: state names the symbol currently on DAT.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      dat_o      <= DAT_IDLE;
      dat_oe_o   <= 1'b0;
      clk_stop_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      shift      <= 8'h00;
      nib_cnt    <= '0;
      crc_cnt    <= 4'd0;
    end else begin
      done_o <= 1'b0;
      if (abort_i && state != ST_IDLE) begin
        state      <= ST_IDLE;
        dat_o      <= DAT_IDLE;
        dat_oe_o   <= 1'b0;
        clk_stop_o <= 1'b0;
        busy_o     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (launch) begin
              state   <= ST_FETCH;
              busy_o  <= 1'b1;
              nib_cnt <= '0;
              crc_cnt <= 4'd0;
            end
          end
          ST_FETCH: begin
            if (consume) begin
              state    <= ST_START;
              shift    <= byte_in;
              dat_o    <= 4'h0;
              dat_oe_o <= 1'b1;
            end
          end
          ST_START: begin
            state   <= ST_DATA;
            dat_o   <= shift[7:4];
            nib_cnt <= NIB_W'(1);
          end
          ST_DATA: begin
            if (nib_cnt == NIB_LAST) begin
              state   <= ST_CRC;
              crc_cnt <= 4'd0;
              dat_o   <= crc_msb;
            end else if (nib_cnt[0]) begin
              dat_o   <= shift[3:0];
              nib_cnt <= nib_cnt + 1'b1;
            end else if (consume) begin
              shift      <= byte_in;
              dat_o      <= byte_in[7:4];
              nib_cnt    <= nib_cnt + 1'b1;
              clk_stop_o <= 1'b0;
            end else begin
              // Underrun: hold DAT and CRCs, ask for the card clock to stop.
              clk_stop_o <= 1'b1;
            end
          end
          ST_CRC: begin
            if (crc_cnt == 4'd15) begin
              state <= ST_STOP;
              dat_o <= DAT_IDLE;
            end else begin
              crc_cnt <= crc_cnt + 1'b1;
              dat_o   <= crc_bit_nxt;
            end
          end
          ST_STOP: begin
            state    <= ST_IDLE;
            dat_oe_o <= 1'b0;
            busy_o   <= 1'b0;
            done_o   <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_data_tx.sv
// ---------------------------------------------------------------------------
// tb_sd_data_tx
//   Bench for sd_data_tx with BLK_BYTES=4. A small FIFO model answers read
//   strobes with one cycle latency and can go empty for a number of cycles
//   after a chosen read. Whole blocks are captured cycle by cycle and
//   checked against a per-line CRC16 model.
// ---------------------------------------------------------------------------
module tb_sd_data_tx;

  logic       sd_clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic       abort_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_dat_i;
  logic [1:0] fifo_adr_o;
  logic       fifo_re_o;
  logic [3:0] dat_o;
  logic       dat_oe_o;
  logic       clk_stop_o;
  logic       busy_o;
  logic       done_o;

  always #5 sd_clk = ~sd_clk;

  sd_data_tx #(.BLK_BYTES(4), .FIFO_ADR(2'd0)) dut (
    .sd_clk       (sd_clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_dat_i   (fifo_dat_i),
    .fifo_adr_o   (fifo_adr_o),
    .fifo_re_o    (fifo_re_o),
    .dat_o        (dat_o),
    .dat_oe_o     (dat_oe_o),
    .clk_stop_o   (clk_stop_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  // FIFO model
  logic [7:0] mem [8];
  int  fill;
  int  stall_after;
  int  stall_len;
  logic fifo_clr;
  int  rd_ptr;
  int  hold_cnt;
  int  re_count;

  always @(posedge sd_clk) begin
    if (fifo_clr) begin
      rd_ptr     <= 0;
      hold_cnt   <= 0;
      re_count   <= 0;
      fifo_dat_i <= 8'h00;
    end else begin
      if (fifo_re_o) begin
        fifo_dat_i <= mem[rd_ptr];
        rd_ptr     <= rd_ptr + 1;
        re_count   <= re_count + 1;
      end
      if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
      else if (fifo_re_o && stall_after != 0 && rd_ptr + 1 == stall_after) hold_cnt <= stall_len;
    end
  end

  assign fifo_empty_i = (rd_ptr >= fill) || (hold_cnt != 0);

  // Scoreboard
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_line(input logic [31:0] d, input int ln);
    logic [15:0] c;
    logic [3:0]  nib;
    logic        fb;
    c = 16'h0000;
    for (int n = 0; n < 8; n++) begin
      nib = d[31-4*n -: 4];
      fb  = nib[ln] ^ c[15];
      c   = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Block capture
  logic [3:0] s_dat  [256];
  logic       s_oe   [256];
  logic       s_stop [256];
  logic       s_done [256];
  int         n_s;
  logic       got_done;

  task automatic load_fifo(input logic [31:0] d, input int n, input int s_after, input int s_len);
    @(negedge sd_clk);
    for (int i = 0; i < 4; i++) mem[i] = d[31-8*i -: 8];
    for (int i = 4; i < 8; i++) mem[i] = 8'h55;
    fill        = n;
    stall_after = s_after;
    stall_len   = s_len;
    fifo_clr    = 1'b1;
    @(negedge sd_clk);
    fifo_clr    = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge sd_clk);
    start_i = 1'b1;
    @(negedge sd_clk);
    start_i = 1'b0;
  endtask

  task automatic run_block(input int budget);
    n_s      = 0;
    got_done = 1'b0;
    for (int c = 0; c < budget && !got_done; c++) begin
      @(negedge sd_clk);
      s_dat[n_s]  = dat_o;
      s_oe[n_s]   = dat_oe_o;
      s_stop[n_s] = clk_stop_o;
      s_done[n_s] = done_o;
      if (done_o) got_done = 1'b1;
      n_s++;
    end
  endtask

  task automatic check_block(input logic [31:0] d, input string tag, input int lo, input int hi);
    logic [3:0]  seq [32];
    logic [15:0] got;
    int seq_n, stalls, freeze_bad, dones, bad_data;
    seq_n = 0; stalls = 0; freeze_bad = 0; dones = 0; bad_data = 0;
    for (int i = 0; i < 32; i++) seq[i] = 4'hx;
    chk({tag, "_done_seen"}, 32'(got_done), 32'd1);
    for (int k = 0; k < n_s; k++) begin
      if (s_done[k]) dones++;
      if (s_oe[k]) begin
        if (s_stop[k]) begin
          stalls++;
          if (k == 0 || s_dat[k] !== s_dat[k-1]) freeze_bad++;
        end else begin
          if (seq_n < 32) seq[seq_n] = s_dat[k];
          seq_n++;
        end
      end
    end
    chk({tag, "_bus_cycles"}, 32'(seq_n), 32'd26);
    chk({tag, "_start_bit"}, 32'(seq[0]), 32'h0);
    for (int n = 0; n < 8; n++)
      if (seq[1+n] !== d[31-4*n -: 4]) bad_data++;
    chk({tag, "_data_nibbles_bad"}, 32'(bad_data), 32'd0);
    for (int ln = 0; ln < 4; ln++) begin
      got = 16'h0000;
      for (int k = 0; k < 16; k++) got[15-k] = seq[9+k][ln];
      chk($sformatf("%s_crc_line%0d", tag, ln), 32'(got), 32'(crc_line(d, ln)));
    end
    chk({tag, "_end_bit"}, 32'(seq[25]), 32'hF);
    chk({tag, "_done_pulses"}, 32'(dones), 32'd1);
    chk({tag, "_done_oe_off"}, 32'(s_oe[n_s-1]), 32'd0);
    chk({tag, "_stall_in_range"}, 32'(stalls >= lo && stalls <= hi), 32'd1);
    chk({tag, "_stall_freeze_bad"}, 32'(freeze_bad), 32'd0);
    chk({tag, "_fifo_reads"}, 32'(re_count), 32'd4);
  endtask

  typedef struct {
    logic [31:0] data;
    int          s_after;
    int          s_len;
    int          stall_lo;
    int          stall_hi;
  } vec_t;

  vec_t vecs [4];
  int   act_cnt;
  int   ok;

  initial begin
    vecs[0] = '{32'h0000_0000, 0, 0, 0, 0};
    vecs[1] = '{32'hA53C_5A0F, 0, 0, 0, 0};
    vecs[2] = '{32'hFF01_80E7, 2, 10, 6, 10};
    vecs[3] = '{32'hA53C_5A0F, 2, 10, 6, 10};

    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    fill = 0; stall_after = 0; stall_len = 0; fifo_clr = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    repeat (3) @(posedge sd_clk);
    #1;
    chk("rst_dat", 32'(dat_o), 32'hF);
    chk("rst_oe", 32'(dat_oe_o), 32'd0);
    chk("rst_re", 32'(fifo_re_o), 32'd0);
    chk("rst_clk_stop", 32'(clk_stop_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("fifo_adr", 32'(fifo_adr_o), 32'd0);
    @(negedge sd_clk);
    rst = 1'b0;
    fifo_clr = 1'b0;

    for (int v = 0; v < 4; v++) begin
      load_fifo(vecs[v].data, 4, vecs[v].s_after, vecs[v].s_len);
      pulse_start();
      run_block(200);
      check_block(vecs[v].data, $sformatf("vec%0d", v), vecs[v].stall_lo, vecs[v].stall_hi);
    end

    // Abort in the middle of DATA, then a fresh block.
    load_fifo(32'h1234_5678, 4, 0, 0);
    pulse_start();
    ok = 0;
    for (int c = 0; c < 30 && ok == 0; c++) begin
      @(negedge sd_clk);
      if (dat_oe_o) ok = 1;
    end
    chk("abort_wait_oe", 32'(ok), 32'd1);
    repeat (3) @(negedge sd_clk);
    abort_i = 1'b1;
    @(posedge sd_clk);
    #1;
    chk("abort_oe", 32'(dat_oe_o), 32'd0);
    chk("abort_dat", 32'(dat_o), 32'hF);
    chk("abort_busy", 32'(busy_o), 32'd0);
    chk("abort_done", 32'(done_o), 32'd0);
    @(negedge sd_clk);
    abort_i = 1'b0;
    act_cnt = 0;
    repeat (40) begin
      @(negedge sd_clk);
      if (done_o || dat_oe_o || busy_o) act_cnt++;
    end
    chk("abort_quiet", 32'(act_cnt), 32'd0);
    load_fifo(32'hC396_0FF0, 4, 0, 0);
    pulse_start();
    run_block(200);
    check_block(32'hC396_0FF0, "fresh", 0, 0);

    // start_i held through the block and into the done cycle.
    load_fifo(32'h5AA5_6996, 8, 0, 0);
    @(negedge sd_clk);
    start_i = 1'b1;
    run_block(200);
    @(posedge sd_clk);
    #1;
    start_i = 1'b0;
    check_block(32'h5AA5_6996, "held", 0, 0);
    act_cnt = 0;
    repeat (40) begin
      @(negedge sd_clk);
      if (busy_o || dat_oe_o || fifo_re_o) act_cnt++;
    end
    chk("held_no_second_block", 32'(act_cnt), 32'd0);
    chk("held_fifo_reads", 32'(re_count), 32'd4);

    // Asynchronous reset in the CRC phase.
    load_fifo(32'h0F1E_2D3C, 8, 0, 0);
    pulse_start();
    ok = 0;
    for (int c = 0; c < 30 && ok == 0; c++) begin
      @(negedge sd_clk);
      if (dat_oe_o) ok = 1;
    end
    chk("rst_wait_oe", 32'(ok), 32'd1);
    repeat (12) @(negedge sd_clk);
    rst = 1'b1;
    #1;
    chk("midrst_dat", 32'(dat_o), 32'hF);
    chk("midrst_oe", 32'(dat_oe_o), 32'd0);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_re", 32'(fifo_re_o), 32'd0);
    chk("midrst_clk_stop", 32'(clk_stop_o), 32'd0);
    act_cnt = 0;
    repeat (3) begin
      @(negedge sd_clk);
      if (fifo_re_o) act_cnt++;
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge sd_clk);
      if (fifo_re_o || busy_o) act_cnt++;
    end
    chk("midrst_no_reads", 32'(act_cnt), 32'd0);
    chk("midrst_fifo_reads", 32'(re_count), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
